fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers in-order responses
// as {pc, inst} entries, and flushes/discards outstanding fetches on a redirect.
module fetch_queue #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    INST_WIDTH      = 32,
    parameter int                    DEPTH           = 4,
    parameter logic [ADDR_WIDTH-1:0] INST_START_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_WIDTH-1:0]       mem_req_addr,
    input  logic                        mem_rsp_valid,
    input  logic [INST_WIDTH-1:0]       mem_rsp_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INST_WIDTH-1:0]       out_inst,
    output logic [ADDR_WIDTH-1:0]       out_pc,
    input  logic                        redirect_en,
    input  logic [ADDR_WIDTH-1:0]       redirect_addr,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h0000_0013);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic                  active_q, active_d;
    logic [ADDR_WIDTH-1:0] pc_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_d [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_d [DEPTH];

    logic [OCC_W-1:0]      occupancy;
    logic [PTR_W-1:0]      res_ptr;
    logic                  accept;
    logic                  rsp_drop;
    logic                  rsp_kept;
    logic                  push;
    logic                  pop;
    logic                  redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_addr[1:0];

    // Every outstanding fetch (kept or to-be-discarded) holds a slot, so a response always fits.
    always_comb begin
        occupancy     = {1'b0, count_q} + {1'b0, inflight_q} + {1'b0, discard_q};
        mem_req_valid = active_q && !redirect_en && (occupancy < OCC_W'(DEPTH));
        mem_req_addr  = fetch_pc_q;
        accept        = mem_req_valid && mem_req_ready;
        rsp_drop      = (discard_q != '0);
        rsp_kept      = mem_rsp_valid && !rsp_drop;
        push          = rsp_kept && !redirect_en;
        out_valid     = (count_q != '0);
        pop           = out_valid && out_ready;
        res_ptr       = tail_q + inflight_q[PTR_W-1:0];
        count         = count_q;
        out_inst      = out_valid ? inst_mem_q[head_q] : NOP_INST;
        out_pc        = out_valid ? pc_mem_q[head_q] : fetch_pc_q;
    end

    // The pc is parked in the slot its response will later land in (tail + kept in-flight).
    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (accept) begin
            pc_mem_d[res_ptr] = fetch_pc_q;
        end
        if (push) begin
            inst_mem_d[tail_q] = mem_rsp_data;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        head_d     = head_q;
        tail_d     = tail_q;
        active_d   = 1'b1;
        if (redirect_en) begin
            // All outstanding fetches become discards; a response this cycle retires one of them.
            fetch_pc_d = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
            count_d    = '0;
            inflight_d = '0;
            head_d     = '0;
            tail_d     = '0;
            discard_d  = discard_q + inflight_q - CNT_W'(mem_rsp_valid);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (mem_rsp_valid && rsp_drop) begin
                discard_d = discard_q - CNT_W'(1);
            end
            inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(rsp_kept);
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= INST_START_ADDR;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            active_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            active_q   <= active_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model with an in-order random-latency
// memory, directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [IW-1:0] mem_rsp_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_inst;
    logic [AW-1:0] out_pc;
    logic          redirect_en;
    logic [AW-1:0] redirect_addr;
    logic [2:0]    count;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_WIDTH(AW),
        .INST_WIDTH(IW),
        .DEPTH(DEPTH),
        .INST_START_ADDR(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst(out_inst),
        .out_pc(out_pc),
        .redirect_en(redirect_en),
        .redirect_addr(redirect_addr),
        .count(count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mrsp_t;

    entry_t      filled[$];
    logic [31:0] pend_pc[$];
    int          discard = 0;
    logic [31:0] fetch_pc = 32'h0;
    bit          active = 1'b0;

    mrsp_t       mq[$];
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rel_cyc = 0;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    bit          dut_acc = 1'b0;

    logic [31:0] acc_log[$];
    int          acc_cyc[$];
    logic [31:0] pop_log[$];
    int          pop_cyc[$];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit expReqValid();
        return active && !redirect_en && ((filled.size() + pend_pc.size() + discard) < DEPTH);
    endfunction

    function automatic logic [31:0] accAt(input int i);
        return (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] popAt(input int i);
        return (i < pop_log.size()) ? pop_log[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic int accCycAt(input int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
    endfunction

    function automatic int popCycAt(input int i);
        return (i < pop_cyc.size()) ? pop_cyc[i] : -1;
    endfunction

    task automatic checkOutput();
        bit          exp_v;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        exp_v    = expReqValid();
        exp_pc   = (filled.size() > 0) ? filled[0].pc : fetch_pc;
        exp_inst = (filled.size() > 0) ? filled[0].inst : NOP;
        checkVal("mem_req_valid", 32'(mem_req_valid), 32'(exp_v));
        if (exp_v) checkVal("mem_req_addr", mem_req_addr, fetch_pc);
        checkVal("out_valid", 32'(out_valid), 32'(filled.size() > 0));
        checkVal("count", 32'(count), 32'(filled.size()));
        checkVal("out_pc", out_pc, exp_pc);
        checkVal("out_inst", out_inst, exp_inst);
    endtask

    // Compare process: samples handshakes and checks outputs mid-cycle, away from the edge.
    always @(negedge clk) begin
        dut_acc = (mem_req_valid === 1'b1) && mem_req_ready;
        if (dut_acc) begin
            acc_log.push_back(mem_req_addr);
            acc_cyc.push_back(cyc);
        end
        if ((out_valid === 1'b1) && out_ready) begin
            pop_log.push_back(out_pc);
            pop_cyc.push_back(cyc);
        end
        if (chk_en) checkOutput();
    end

    task automatic modelStep();
        bit          acc;
        bit          pop;
        logic [31:0] pc;
        if (!reset) begin
            filled.delete();
            pend_pc.delete();
            discard  = 0;
            fetch_pc = 32'h0;
            active   = 1'b0;
            mq.delete();
        end else begin
            acc = expReqValid() && mem_req_ready;
            pop = (filled.size() > 0) && out_ready;
            if (pop) void'(filled.pop_front());
            if (mem_rsp_valid) begin
                if (discard > 0) begin
                    discard--;
                end else if (pend_pc.size() > 0) begin
                    pc = pend_pc.pop_front();
                    if (!redirect_en) filled.push_back('{pc: pc, inst: mem_rsp_data});
                end
            end
            if (redirect_en) begin
                discard += pend_pc.size();
                pend_pc.delete();
                filled.delete();
                fetch_pc = {redirect_addr[31:2], 2'b00};
            end else if (acc) begin
                pend_pc.push_back(fetch_pc);
                fetch_pc = fetch_pc + 32'd4;
            end
            if (dut_acc) mq.push_back('{due: cyc + $urandom_range(lat_max, lat_min), data: $urandom});
            if (mem_rsp_valid) void'(mq.pop_front());
            active = 1'b1;
        end
    endtask

    task automatic applyStimulus(input bit rdy, input bit ordy, input bit redir, input logic [31:0] raddr);
        mem_req_ready = rdy;
        out_ready     = ordy;
        redirect_en   = redir;
        redirect_addr = raddr;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mq[0].data;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end
        @(posedge clk);
        modelStep();
        cyc++;
        #1;
    endtask

    task automatic resetDut();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 32'h0);
        chk_en = 1'b1;
        repeat (2) applyStimulus(0, 0, 0, 32'h0);
        reset = 1'b1;
        acc_log.delete();
        acc_cyc.delete();
        pop_log.delete();
        pop_cyc.delete();
        rel_cyc = cyc;
    endtask

    initial begin
        reset         = 1'b0;
        mem_req_ready = 1'b0;
        out_ready     = 1'b0;
        redirect_en   = 1'b0;
        redirect_addr = '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        #2;

        // Straight-line fetch with a 1-cycle memory
        lat_min = 1; lat_max = 1;
        resetDut();
        checkVal("rst_req_valid", 32'(mem_req_valid), 32'h0);
        checkVal("rst_count", 32'(count), 32'h0);
        checkVal("rst_out_valid", 32'(out_valid), 32'h0);
        checkVal("rst_out_pc", out_pc, 32'h0);
        checkVal("rst_out_inst", out_inst, 32'h13);
        repeat (8) applyStimulus(1, 1, 0, 32'h0);
        checkVal("A_acc0", accAt(0), 32'h0);
        checkVal("A_acc1", accAt(1), 32'h4);
        checkVal("A_acc2", accAt(2), 32'h8);
        checkVal("A_first_req_cycle", accCycAt(0), rel_cyc + 1);
        checkVal("A_third_req_cycle", accCycAt(2), rel_cyc + 3);
        checkVal("A_pop0", popAt(0), 32'h0);
        checkVal("A_pop1", popAt(1), 32'h4);
        checkVal("A_pop2", popAt(2), 32'h8);
        checkVal("A_first_pop_cycle", popCycAt(0), rel_cyc + 3);
        checkVal("A_third_pop_cycle", popCycAt(2), rel_cyc + 5);

        // Consumer stalled: queue fills to DEPTH and fetching stops
        resetDut();
        repeat (10) applyStimulus(1, 0, 0, 32'h0);
        checkVal("B_acc_count", acc_log.size(), 32'd4);
        checkVal("B_req_valid", 32'(mem_req_valid), 32'h0);
        checkVal("B_count_full", 32'(count), 32'd4);
        checkVal("B_head_pc", out_pc, 32'h0);
        repeat (4) applyStimulus(1, 1, 0, 32'h0);
        checkVal("B_resume_addr", accAt(4), 32'h10);

        // Redirect with three fetches outstanding on a 5-cycle memory
        lat_min = 5; lat_max = 5;
        resetDut();
        applyStimulus(0, 1, 0, 32'h0);
        repeat (3) applyStimulus(1, 1, 0, 32'h0);
        applyStimulus(1, 1, 1, 32'h103);
        checkVal("C_no_req_in_redirect", acc_log.size(), 32'd3);
        repeat (16) applyStimulus(1, 1, 0, 32'h0);
        checkVal("C_redirect_addr", accAt(3), 32'h100);
        checkVal("C_next_addr", accAt(4), 32'h104);
        checkVal("C_first_out_pc", popAt(0), 32'h100);

        // Memory back-pressure holds the address
        lat_min = 1; lat_max = 1;
        resetDut();
        applyStimulus(0, 1, 0, 32'h0);
        repeat (2) applyStimulus(1, 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkVal("D_hold_addr", mem_req_addr, 32'h8);
            checkVal("D_hold_valid", 32'(mem_req_valid), 32'h1);
            applyStimulus(0, 1, 0, 32'h0);
        end
        checkVal("D_acc_count", acc_log.size(), 32'd2);

        // Address wrap at the top of the address space
        resetDut();
        applyStimulus(0, 1, 0, 32'h0);
        applyStimulus(0, 1, 1, 32'hFFFF_FFFC);
        repeat (3) applyStimulus(1, 1, 0, 32'h0);
        checkVal("E_addr_top", accAt(0), 32'hFFFF_FFFC);
        checkVal("E_addr_wrap", accAt(1), 32'h0);

        // Redirect, response and pop all in one cycle
        lat_min = 2; lat_max = 2;
        resetDut();
        applyStimulus(0, 0, 0, 32'h0);
        repeat (3) applyStimulus(1, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 32'h200);
        checkVal("F_count_flushed", 32'(count), 32'h0);
        checkVal("F_out_valid", 32'(out_valid), 32'h0);
        checkVal("F_discard", 32'(dut.discard_q), 32'd1);
        checkVal("F_pop_honoured", popAt(0), 32'h0);
        repeat (8) applyStimulus(1, 1, 0, 32'h0);
        checkVal("F_pop_count", pop_log.size() >= 2, 32'h1);
        checkVal("F_after_redirect_pc", popAt(1), 32'h200);

        // Randomized traffic, each run starting from a reset in mid-operation
        for (int r = 0; r < 4; r++) begin
            int rp;
            int op;
            lat_min = 1 + $urandom_range(0, 2);
            lat_max = lat_min + $urandom_range(0, 5);
            rp = 40 + $urandom_range(0, 60);
            op = 30 + $urandom_range(0, 70);
            resetDut();
            repeat (600) applyStimulus($urandom_range(0, 99) < rp, $urandom_range(0, 99) < op,
                                       $urandom_range(0, 99) < 4, $urandom);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
